// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM: one write port and one read port on one clock.
// Features: per-lane write enables, read latency of 1 or 2 cycles, and a
// selectable same-address read-during-write policy.
// A clear engine sweeps zeros through the array after reset or on request.
// The storage array itself has no reset; only the sweep initialises it.
module sdp_ram_param #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/LANE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid
);

  localparam int NL    = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_acc_s, rd_acc_s;
  logic [DATA_W-1:0]   wr_merged_s, rd_word_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic [DATA_W-1:0]   rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic                rd_valid1_q, rd_valid1_d, rd_valid2_q, rd_valid2_d;

  // Replace the enabled lanes of old_w with the matching lanes of new_w.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NL-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) begin
        res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
      end else begin
        res[i*LANE_W +: LANE_W] = old_w[i*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

  // Next-state logic for the clear engine; clr_req is ignored mid-sweep.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = {ADDR_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Port acceptance, array write selection and same-address read forwarding.
  always_comb begin
    wr_acc_s    = wr_en && !busy_q && (wr_be != {NL{1'b0}});
    rd_acc_s    = rd_en && !busy_q;
    wr_merged_s = lane_merge(mem[wr_addr], wr_data, wr_be);
    if (busy_q) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_ptr_q;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_we_s    = wr_acc_s;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_merged_s;
    end
    if ((BYPASS != 0) && wr_acc_s && (wr_addr == rd_addr)) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = mem[rd_addr];
    end
  end

  // Read pipeline: stage 1 captures the read word, stage 2 adds one cycle.
  always_comb begin
    rd_valid1_d = rd_acc_s;
    if (rd_acc_s) begin
      rd_data1_d = rd_word_s;
    end else begin
      rd_data1_d = rd_data1_q;
    end
    rd_valid2_d = rd_valid1_q;
    if (rd_valid1_q) begin
      rd_data2_d = rd_data1_q;
    end else begin
      rd_data2_d = rd_data2_q;
    end
  end

  // Control and read-path registers; all return to idle on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      busy_q      <= 1'b1;
      clr_ptr_q   <= {ADDR_W{1'b0}};
      rd_data1_q  <= {DATA_W{1'b0}};
      rd_valid1_q <= 1'b0;
      rd_data2_q  <= {DATA_W{1'b0}};
      rd_valid2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      clr_ptr_q   <= clr_ptr_d;
      rd_data1_q  <= rd_data1_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data2_q  <= rd_data2_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  // Storage array write; deliberately without reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign busy     = busy_q;
  assign rd_data  = (RD_LAT == 2) ? rd_data2_q  : rd_data1_q;
  assign rd_valid = (RD_LAT == 2) ? rd_valid2_q : rd_valid1_q;

endmodule

// File: tb/tb_sdp_ram_param.sv
// Directed bench for sdp_ram_param. Three instances share the stimulus:
// a = defaults (RD_LAT 1, new-data bypass), b = old-data policy,
// c = two-cycle read latency.
module tb_sdp_ram_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [1:0] wr_be;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic       busy_a, busy_b, busy_c;
  logic [7:0] rd_data_a, rd_data_b, rd_data_c;
  logic       rd_valid_a, rd_valid_b, rd_valid_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdp_ram_param #(.DATA_W(8), .LANE_W(4), .ADDR_W(4), .RD_LAT(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  sdp_ram_param #(.DATA_W(8), .LANE_W(4), .ADDR_W(4), .RD_LAT(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  sdp_ram_param #(.DATA_W(8), .LANE_W(4), .ADDR_W(4), .RD_LAT(2), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_req = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_be   = 2'b00;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0; wr_be = 2'b00;
  endtask

  // Reset values, release, 16-cycle busy window, then all locations read 0.
  task automatic test_reset();
    int cnt;
    idle();
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy_a !== 1'b1 || rd_data_a !== 8'h00 || rd_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b rd_data=%h rd_valid=%b required 1/00/0", busy_a, rd_data_a, rd_valid_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d required=16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00 || rd_valid_b !== 1'b1 || rd_data_b !== 8'h00) begin
        failures++;
        $display("FAIL reset_read_lat1 addr=%0d a=%b/%h b=%b/%h required 1/00", i, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b);
      end
      if (i > 0) begin
        checks++;
        if (rd_valid_c !== 1'b1 || rd_data_c !== 8'h00) begin
          failures++;
          $display("FAIL reset_read_lat2 addr=%0d got=%b/%h required 1/00", i - 1, rd_valid_c, rd_data_c);
        end
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_valid_c !== 1'b1 || rd_data_c !== 8'h00) begin
      failures++;
      $display("FAIL reset_read_tail a_valid=%b c=%b/%h required 0 and 1/00", rd_valid_a, rd_valid_c, rd_data_c);
    end
    step();
  endtask

  // Per-lane write enables, including the all-zero no-op mask.
  task automatic test_lanes();
    write_word(4'd3, 8'hAB, 2'b11);
    write_word(4'd3, 8'h5C, 2'b01);
    write_word(4'd3, 8'hFF, 2'b00);
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data_a !== 8'hAC || rd_valid_a !== 1'b1 || rd_data_b !== 8'hAC) begin
      failures++;
      $display("FAIL lane_merge a=%b/%h b=%h required 1/ac ac", rd_valid_a, rd_data_a, rd_data_b);
    end
    step();
    checks++;
    if (rd_data_c !== 8'hAC || rd_valid_c !== 1'b1 || rd_valid_a !== 1'b0 || rd_data_a !== 8'hAC) begin
      failures++;
      $display("FAIL lane_merge_lat2 c=%b/%h a=%b/%h required 1/ac 0/ac", rd_valid_c, rd_data_c, rd_valid_a, rd_data_a);
    end
  endtask

  // Same-address read during write under both policies; distinct addresses.
  task automatic test_bypass();
    write_word(4'd5, 8'h11, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h77; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    checks++;
    if (rd_data_a !== 8'h77 || rd_data_b !== 8'h11) begin
      failures++;
      $display("FAIL bypass_full new=%h required 77 old=%h required 11", rd_data_a, rd_data_b);
    end
    wr_data = 8'h99; wr_be = 2'b10;
    step();
    checks++;
    if (rd_data_a !== 8'h97 || rd_data_b !== 8'h77 || rd_data_c !== 8'h77) begin
      failures++;
      $display("FAIL bypass_partial new=%h required 97 old=%h required 77 lat2=%h required 77", rd_data_a, rd_data_b, rd_data_c);
    end
    wr_addr = 4'd6; wr_data = 8'h66; wr_be = 2'b11;
    step();
    checks++;
    if (rd_data_a !== 8'h97 || rd_data_b !== 8'h97 || rd_valid_b !== 1'b1) begin
      failures++;
      $display("FAIL diff_addr a=%h b=%b/%h required 97 1/97", rd_data_a, rd_valid_b, rd_data_b);
    end
    idle();
    rd_en = 1'b1; rd_addr = 4'd6;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data_a !== 8'h66 || rd_data_b !== 8'h66) begin
      failures++;
      $display("FAIL diff_addr_write a=%h b=%h required 66", rd_data_a, rd_data_b);
    end
    step();
    step();
  endtask

  // Back-to-back reads: latency 1 and 2 pipelines, then hold behaviour.
  task automatic test_back_to_back();
    logic [7:0] exp_c [5];
    logic       exp_v [5];
    write_word(4'd1, 8'h21, 2'b11);
    write_word(4'd2, 8'h32, 2'b11);
    write_word(4'd3, 8'h43, 2'b11);
    exp_v[0] = 1'b0; exp_c[0] = 8'h66;
    exp_v[1] = 1'b1; exp_c[1] = 8'h21;
    exp_v[2] = 1'b1; exp_c[2] = 8'h32;
    exp_v[3] = 1'b1; exp_c[3] = 8'h43;
    exp_v[4] = 1'b0; exp_c[4] = 8'h43;
    for (int i = 0; i < 5; i++) begin
      rd_en   = (i < 3) ? 1'b1 : 1'b0;
      rd_addr = 4'(i + 1);
      step();
      checks++;
      if (rd_valid_c !== exp_v[i] || rd_data_c !== exp_c[i]) begin
        failures++;
        $display("FAIL b2b_lat2 cycle=%0d got=%b/%h required %b/%h", i, rd_valid_c, rd_data_c, exp_v[i], exp_c[i]);
      end
      if (i < 3) begin
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== exp_c[i + 1]) begin
          failures++;
          $display("FAIL b2b_lat1 cycle=%0d got=%b/%h required 1/%h", i, rd_valid_a, rd_data_a, exp_c[i + 1]);
        end
      end
    end
    step();
    checks++;
    if (rd_data_c !== 8'h43 || rd_valid_c !== 1'b0 || rd_data_a !== 8'h43) begin
      failures++;
      $display("FAIL b2b_hold c=%b/%h a=%h required 0/43 43", rd_valid_c, rd_data_c, rd_data_a);
    end
  endtask

  // Clear request over a full array; ops dropped while busy; re-request ignored.
  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 16; i++) write_word(4'(i), 8'hFF, 2'b11);
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
    step();
    clr_req = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || rd_valid_a !== 1'b1 || rd_data_a !== 8'hFF) begin
      failures++;
      $display("FAIL clr_same_cycle busy=%b read=%b/%h required 1 1/ff", busy_a, rd_valid_a, rd_data_a);
    end
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++;
      clr_req = (cnt == 5) ? 1'b1 : 1'b0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 4'(cnt);
      step();
      checks++;
      if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || (cnt > 1 && rd_valid_c !== 1'b0)) begin
        failures++;
        $display("FAIL clr_drop_read cycle=%0d valid a/b/c=%b%b%b required 000", cnt, rd_valid_a, rd_valid_b, rd_valid_c);
      end
    end
    idle();
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL clr_busy_len got=%0d required=16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
        failures++;
        $display("FAIL clr_read addr=%0d a=%b/%h b=%h required 1/00 00", i, rd_valid_a, rd_data_a, rd_data_b);
      end
    end
    idle();
    step();
    step();
  endtask

  // Reset pulse mid-sweep restarts the full sweep from address 0.
  task automatic test_reset_mid_sweep();
    int cnt;
    write_word(4'd10, 8'h5A, 2'b11);
    write_word(4'd15, 8'hA5, 2'b11);
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd10;
    step();
    idle();
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy_a !== 1'b1 || rd_valid_a !== 1'b0 || rd_data_a !== 8'h00 || rd_valid_c !== 1'b0 || rd_data_c !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_outputs busy=%b a=%b/%h c=%b/%h required 1 0/00 0/00", busy_a, rd_valid_a, rd_data_a, rd_valid_c, rd_data_c);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++;
      step();
      checks++;
      if (rd_valid_a !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_valid cycle=%0d got=%b required 0", cnt, rd_valid_a);
      end
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL mid_reset_busy_len got=%0d required=16", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(15 - i);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin
        failures++;
        $display("FAIL mid_reset_read addr=%0d got=%b/%h required 1/00", 15 - i, rd_valid_a, rd_data_a);
      end
    end
    idle();
    step();
  endtask

  initial begin
    wr_addr = 4'd0; wr_data = 8'h00; rd_addr = 4'd0;
    test_reset();
    test_lanes();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
